// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester round-robin arbiter feeding an 8N1 UART transmitter
// Ports: clk, rst (async, active-high); reqN_valid/reqN_data/reqN_ready byte handshake per requester;
//        tx serial line (idle high); busy while a frame is on the line; grant_id owner of current/last frame.
module uart_tx_arb #(
    parameter int DIVISOR = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);
    localparam int CW = $clog2(DIVISOR);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, grant_q, grant_d, last_q, last_d;
    logic          term, sel1;

    assign term = cnt_q == CW'(DIVISOR - 1);
    // On a tie the requester that did not win last time goes first.
    assign sel1 = req1_valid && (!req0_valid || !last_q);
    assign req1_ready = state_q == IDLE && sel1;
    assign req0_ready = state_q == IDLE && req0_valid && !sel1;
    assign busy = state_q != IDLE;
    assign tx = tx_q;
    assign grant_id = grant_q;

    always_comb begin
        state_d = state_q;
        cnt_d = (state_q == IDLE || term) ? '0 : cnt_q + 1'b1;
        bit_d = bit_q;
        shift_d = shift_q;
        tx_d = tx_q;
        grant_d = grant_q;
        last_d = last_q;
        if (state_q == IDLE) begin
            if (req0_ready || req1_ready) begin
                state_d = START;
                shift_d = req1_ready ? req1_data : req0_data;
                grant_d = req1_ready;
                last_d = req1_ready;
                bit_d = '0;
                tx_d = 1'b0;
            end
        end else if (term) begin
            // tx is registered, so it is loaded with the level of the bit about to start.
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    tx_d = shift_q[0];
                end
                DATA: begin
                    bit_d = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    state_d = bit_q == 3'd7 ? STOP : DATA;
                    tx_d = bit_q == 3'd7 ? 1'b1 : shift_q[1];
                end
                default: begin
                    state_d = IDLE;
                    tx_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            tx_q <= 1'b1;
            grant_q <= 1'b0;
            last_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            tx_q <= tx_d;
            grant_q <= grant_d;
            last_q <= last_d;
        end
    end
endmodule
